// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared definitions for the serial LCD blocks: word layout,
//               panel command bytes, RGB565 colours and the SPI writer FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  // Command/data word layout: [8] = D/C flag, [7:0] = byte
  localparam int c_DC_BIT = 8;
  localparam int c_WORD_W = 9;

  // Panel command bytes
  localparam logic [7:0] c_CMD_RAMWR  = 8'h2C;
  localparam logic [7:0] c_CMD_CASET  = 8'h2A;
  localparam logic [7:0] c_CMD_RASET  = 8'h2B;
  localparam logic [7:0] c_CMD_SLPOUT = 8'h11;
  localparam logic [7:0] c_CMD_DISPON = 8'h29;

  // RGB565 colours shared with the sequencers
  localparam logic [15:0] c_RGB_BLACK  = 16'h0000;
  localparam logic [15:0] c_RGB_WHITE  = 16'hFFFF;
  localparam logic [15:0] c_RGB_RED    = 16'hF800;
  localparam logic [15:0] c_RGB_GREEN  = 16'h07E0;
  localparam logic [15:0] c_RGB_BLUE   = 16'h001F;
  localparam logic [15:0] c_RGB_YELLOW = 16'hFFE0;

  // SPI writer FSM encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/lcd_spi_tick.sv
`default_nettype none
// ============================================================================
// Module      : lcd_spi_tick
// Description : Half-period down-counter. While en_i is high, tick_o pulses
//               for one cycle every HALF_CYC cycles; the first tick comes
//               HALF_CYC cycles after enable rises. Reloaded while disabled.
// Ports       : clk_i   - clock
//               rst_n_i - asynchronous active-low reset
//               en_i    - count enable
//               tick_o  - one-cycle tick (combinational from the counter)
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_spi_tick #(
  parameter int HALF_CYC = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [7:0] c_RELOAD = 8'(HALF_CYC - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tick_o = en_i && (cnt_q == 8'd0);

  always_comb begin
    cnt_d = c_RELOAD;
    if (en_i && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= c_RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : lcd_spi_tick
`default_nettype wire

// File: rtl/lcd_spi_write.sv
`default_nettype none
// ============================================================================
// Module      : lcd_spi_write
// Description : Byte-level SPI (mode 0) transmitter for the 4-wire serial LCD.
//               Accepts a 9-bit D/C + byte word, shifts the byte MSB-first and
//               pulses wr_done_o once per byte.
// Ports       : sys_clk_i   - clock
//               sys_rst_n_i - asynchronous active-low reset
//               data_i      - [8] D/C flag, [7:0] byte
//               en_write_i  - level request, sampled only when idle
//               wr_done_o   - one-cycle pulse per completed byte
//               busy_o      - high from accept through end of gap
//               lcd_cs_n_o, lcd_sclk_o, lcd_mosi_o, lcd_dc_o - panel pins
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_spi_write
  import lcd_pkg::*;
#(
  parameter int HALF_CYC  = 2,
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 1,
  parameter int GAP_CYC   = 4
) (
  input  logic                sys_clk_i,
  input  logic                sys_rst_n_i,
  input  logic [c_WORD_W-1:0] data_i,
  input  logic                en_write_i,
  output logic                wr_done_o,
  output logic                busy_o,
  output logic                lcd_cs_n_o,
  output logic                lcd_sclk_o,
  output logic                lcd_mosi_o,
  output logic                lcd_dc_o
);

  // Phase counters are loaded with N-1 and leave the state when they hit 0,
  // so each phase lasts exactly N cycles.
  localparam logic [3:0] c_SETUP_LOAD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] c_HOLD_LOAD  = 4'(HOLD_CYC - 1);
  localparam logic [3:0] c_GAP_LOAD   = 4'(GAP_CYC - 1);

  spi_state_e state_q;
  logic [6:0] shift_q;  // remaining bits; bit 7 goes straight to MOSI at accept
  logic [2:0] bit_q;
  logic [3:0] cnt_q;
  logic       cs_n_q;
  logic       sclk_q;
  logic       mosi_q;
  logic       dc_q;
  logic       done_q;
  logic       busy_q;

  logic w_tick;
  logic w_accept;

  lcd_spi_tick #(
    .HALF_CYC (HALF_CYC)
  ) u_tick (
    .clk_i   (sys_clk_i),
    .rst_n_i (sys_rst_n_i),
    .en_i    (state_q == ST_SHIFT),
    .tick_o  (w_tick)
  );

  // The last GAP cycle doubles as an IDLE sampling point so that a held
  // request restarts exactly GAP_CYC cycles after wr_done.
  assign w_accept = en_write_i &&
                    ((state_q == ST_IDLE) ||
                     ((state_q == ST_GAP) && (cnt_q == 4'd0)));

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q <= ST_IDLE;
      shift_q <= 7'd0;
      bit_q   <= 3'd0;
      cnt_q   <= 4'd0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      dc_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (w_accept) begin
        shift_q <= data_i[6:0];
        mosi_q  <= data_i[7];
        dc_q    <= data_i[c_DC_BIT];
        cs_n_q  <= 1'b0;
        busy_q  <= 1'b1;
        bit_q   <= 3'd0;
        cnt_q   <= c_SETUP_LOAD;
        state_q <= ST_SETUP;
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_SETUP: begin
            if (cnt_q == 4'd0) state_q <= ST_SHIFT;
            else               cnt_q   <= cnt_q - 4'd1;
          end
          ST_SHIFT: begin
            if (w_tick) begin
              if (!sclk_q) begin
                sclk_q <= 1'b1;
              end else begin
                // Falling edge: the only place MOSI is allowed to move
                sclk_q <= 1'b0;
                if (bit_q == 3'd7) begin
                  cnt_q   <= c_HOLD_LOAD;
                  state_q <= ST_HOLD;
                end else begin
                  bit_q   <= bit_q + 3'd1;
                  mosi_q  <= shift_q[6];
                  shift_q <= {shift_q[5:0], 1'b0};
                end
              end
            end
          end
          ST_HOLD: begin
            if (cnt_q == 4'd0) begin
              cs_n_q  <= 1'b1;
              done_q  <= 1'b1;
              cnt_q   <= c_GAP_LOAD;
              state_q <= ST_GAP;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          ST_GAP: begin
            if (cnt_q == 4'd0) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign wr_done_o  = done_q;
  assign busy_o     = busy_q;
  assign lcd_cs_n_o = cs_n_q;
  assign lcd_sclk_o = sclk_q;
  assign lcd_mosi_o = mosi_q;
  assign lcd_dc_o   = dc_q;

endmodule : lcd_spi_write
`default_nettype wire

// File: tb/tb_lcd_spi_write.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_spi_write
// Description : Self-checking bench for lcd_spi_write at default parameters.
//               A panel-side monitor decodes bytes from the pins; directed
//               vectors and corner-case sequences compare against hand values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_spi_write;
  import lcd_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] data = 9'd0;
  logic       en_write = 1'b0;
  logic       wr_done, busy, lcd_cs_n, lcd_sclk, lcd_mosi, lcd_dc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lcd_spi_write dut (
    .sys_clk_i   (clk),
    .sys_rst_n_i (rst_n),
    .data_i      (data),
    .en_write_i  (en_write),
    .wr_done_o   (wr_done),
    .busy_o      (busy),
    .lcd_cs_n_o  (lcd_cs_n),
    .lcd_sclk_o  (lcd_sclk),
    .lcd_mosi_o  (lcd_mosi),
    .lcd_dc_o    (lcd_dc)
  );

  // ---------------- panel-side monitor ----------------
  typedef struct {
    logic [7:0] bits;
    int         nbits;
    logic       dc;
    int         lat;
    int         first_rise;
    int         unstable;
    int         cs_ok;
    int         acc_cyc;
    int         done_cyc;
  } rec_t;

  rec_t rec_q[$];
  rec_t cur;
  int   abs_cyc = 0;
  int   mon_cyc = 0;
  int   mon_nbits = 0;
  int   done_cnt = 0;
  logic in_byte = 1'b0;
  logic prev_cs = 1'b1;
  logic prev_sclk = 1'b0;
  logic held_mosi = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      abs_cyc++;
      if (!rst_n) begin
        in_byte   = 1'b0;
        prev_cs   = 1'b1;
        prev_sclk = 1'b0;
      end else begin
        if (prev_cs && !lcd_cs_n) begin
          in_byte        = 1'b1;
          cur            = '{default: 0};
          cur.dc         = lcd_dc;
          cur.acc_cyc    = abs_cyc;
          cur.first_rise = -1;
          mon_cyc        = 0;
          mon_nbits      = 0;
        end else if (in_byte) begin
          mon_cyc++;
        end
        if (in_byte) begin
          if (!prev_sclk && lcd_sclk) begin
            cur.bits  = {cur.bits[6:0], lcd_mosi};
            held_mosi = lcd_mosi;
            if (mon_nbits == 0) cur.first_rise = mon_cyc;
            mon_nbits++;
          end else if (lcd_sclk && (lcd_mosi !== held_mosi)) begin
            cur.unstable++;
          end
          if (lcd_dc !== cur.dc) cur.unstable++;
        end
        if (wr_done) begin
          done_cnt++;
          if (in_byte) begin
            cur.lat      = mon_cyc;
            cur.nbits    = mon_nbits;
            cur.done_cyc = abs_cyc;
            cur.cs_ok    = (lcd_cs_n && !prev_cs) ? 1 : 0;
            rec_q.push_back(cur);
            in_byte = 1'b0;
          end
        end
        prev_cs   = lcd_cs_n;
        prev_sclk = lcd_sclk;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_byte(input logic [8:0] w);
    @(negedge clk); #1;
    data     = w;
    en_write = 1'b1;
    @(negedge clk); #1;
    en_write = 1'b0;
  endtask

  task automatic wait_recs(input string name, input int n, input int budget);
    for (int i = 0; i < budget && rec_q.size() < n; i++) begin
      @(negedge clk); #1;
    end
    chk({name, "_rec_count"}, rec_q.size(), n);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20 && busy; i++) begin
      @(negedge clk); #1;
    end
    chk({name, "_busy_end"}, busy, 1'b0);
  endtask

  task automatic pop_rec(output rec_t r);
    if (rec_q.size() > 0) r = rec_q.pop_front();
    else                  r = '{default: 0};
  endtask

  // Defaults: latency 1 + 16*2 + 1 = 34, first SCL rise 1 + 2 = 3
  task automatic check_rec(input string name, input rec_t r,
                           input logic [7:0] exp_bits, input logic exp_dc);
    chk({name, "_bits"},       r.bits, exp_bits);
    chk({name, "_nbits"},      r.nbits, 8);
    chk({name, "_dc"},         r.dc, exp_dc);
    chk({name, "_latency"},    r.lat, 34);
    chk({name, "_first_rise"}, r.first_rise, 3);
    chk({name, "_stable"},     r.unstable, 0);
    chk({name, "_cs_rise"},    r.cs_ok, 1);
  endtask

  typedef struct {
    logic [8:0] data;
    logic [7:0] exp_bits;
    logic       exp_dc;
  } vec_t;

  vec_t vecs[5];
  rec_t r, r2;
  int   saved_done;

  initial begin
    vecs[0] = '{{1'b0, c_CMD_RAMWR}, 8'b0010_1100, 1'b0};
    vecs[1] = '{9'h1BC,              8'b1011_1100, 1'b1};
    vecs[2] = '{9'h0FF,              8'b1111_1111, 1'b0};
    vecs[3] = '{9'h100,              8'b0000_0000, 1'b1};
    vecs[4] = '{9'h055,              8'b0101_0101, 1'b0};

    // ---- reset ----
    repeat (5) @(negedge clk);
    chk("rst_cs_n",    lcd_cs_n, 1'b1);
    chk("rst_sclk",    lcd_sclk, 1'b0);
    chk("rst_mosi",    lcd_mosi, 1'b0);
    chk("rst_dc",      lcd_dc,   1'b0);
    chk("rst_wr_done", wr_done,  1'b0);
    chk("rst_busy",    busy,     1'b0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---- single bytes from the table ----
    for (int v = 0; v < 5; v++) begin
      rec_q.delete();
      start_byte(vecs[v].data);
      chk($sformatf("vec%0d_busy", v), busy, 1'b1);
      wait_recs($sformatf("vec%0d", v), 1, 60);
      pop_rec(r);
      check_rec($sformatf("vec%0d", v), r, vecs[v].exp_bits, vecs[v].exp_dc);
      wait_idle($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_dc_hold", v), lcd_dc, vecs[v].exp_dc);
      chk($sformatf("vec%0d_cs_idle", v), lcd_cs_n, 1'b1);
    end

    // ---- continuous request: F8 then 00, accept 4 cycles after wr_done ----
    rec_q.delete();
    @(negedge clk); #1;
    data     = 9'h1F8;
    en_write = 1'b1;
    wait_recs("cont_first", 1, 60);
    repeat (2) @(negedge clk);
    data = 9'h100;
    for (int i = 0; i < 10 && lcd_cs_n; i++) begin
      @(negedge clk); #1;
    end
    chk("cont_second_cs", lcd_cs_n, 1'b0);
    en_write = 1'b0;
    wait_recs("cont_second", 2, 60);
    pop_rec(r);
    pop_rec(r2);
    check_rec("cont_b0", r, 8'hF8, 1'b1);
    check_rec("cont_b1", r2, 8'h00, 1'b1);
    chk("cont_gap", r2.acc_cyc - r.done_cyc, 4);
    wait_idle("cont");

    // ---- input change during bit 2 ----
    rec_q.delete();
    start_byte(9'h1A5);
    for (int i = 0; i < 40 && mon_nbits < 2; i++) begin
      @(negedge clk); #1;
    end
    chk("midchg_bit2", mon_nbits, 2);
    data = 9'h0FF;
    wait_recs("midchg", 1, 60);
    pop_rec(r);
    check_rec("midchg", r, 8'hA5, 1'b1);
    wait_idle("midchg");
    chk("midchg_dc_hold", lcd_dc, 1'b1);

    // ---- reset mid-byte ----
    rec_q.delete();
    start_byte(9'h02C);
    for (int i = 0; i < 40 && mon_nbits < 3; i++) begin
      @(negedge clk); #1;
    end
    chk("rstmid_rise3", mon_nbits, 3);
    saved_done = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("rstmid_cs_n", lcd_cs_n, 1'b1);
    chk("rstmid_sclk", lcd_sclk, 1'b0);
    chk("rstmid_busy", busy,     1'b0);
    chk("rstmid_dc",   lcd_dc,   1'b0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (45) @(negedge clk);
    #1;
    chk("rstmid_no_done", done_cnt - saved_done, 0);
    chk("rstmid_no_rec",  rec_q.size(), 0);
    start_byte(9'h02C);
    wait_recs("rstmid_fresh", 1, 60);
    pop_rec(r);
    check_rec("rstmid_fresh", r, 8'h2C, 1'b0);
    wait_idle("rstmid_fresh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule : tb_lcd_spi_write
`default_nettype wire
